// File: rtl/mapreduce_job_ctrl.sv
// Job sequencer for map_reducer: clear, stream a fixed number of beats, drain,
// then latch the reduced count and raise a completion interrupt.
module mapreduce_job_ctrl #(
    parameter int LEN_W        = 32,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_job_len_wr,
    input  logic [LEN_W-1:0] i_job_len,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_irq_ack,
    input  logic             i_strm_data_valid,
    output logic             o_strm_data_rdy,
    output logic             o_mr_data_valid,
    input  logic             i_mr_data_rdy,
    output logic             o_mr_clr,
    input  logic [31:0]      i_mr_data_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_irq,
    output logic [LEN_W-1:0] o_beat_count,
    output logic [31:0]      o_result
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_job_len;
    logic [LEN_W-1:0] r_beat_count;
    logic [CLR_W-1:0] r_clr_cnt;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [31:0]      r_result;
    logic             r_irq;

    logic             w_idle_like;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_beat_inc;
    logic             w_start_job;
    logic             w_start_empty;
    logic             w_beat;
    logic             w_last_beat;
    logic             w_clr_done;
    logic             w_drain_done;
    logic             w_enter_done;

    always_comb begin
        w_idle_like   = (r_state == ST_IDLE) || (r_state == ST_DONE);
        // A length written in the same cycle as start is the one the job uses.
        w_len_eff     = i_job_len_wr ? i_job_len : r_job_len;
        w_start_job   = w_idle_like && i_start && (w_len_eff != '0);
        w_start_empty = w_idle_like && i_start && (w_len_eff == '0);
        w_beat_inc    = r_beat_count + LEN_W'(1);
        // Abort wins over a same-cycle beat, so the partial count stays exact.
        w_beat        = (r_state == ST_RUN) && i_strm_data_valid && i_mr_data_rdy && !i_abort;
        w_last_beat   = w_beat && (w_beat_inc == r_job_len);
        w_clr_done    = (r_state == ST_CLEAR) && (r_clr_cnt == CLR_LAST);
        w_drain_done  = (r_state == ST_DRAIN) && (r_drain_cnt == DRN_LAST);
        w_enter_done  = (w_drain_done && !i_abort) || w_start_empty;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        o_mr_clr        = 1'b0;
        o_strm_data_rdy = 1'b0;
        o_mr_data_valid = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                o_done = (r_state == ST_DONE);
                if (w_start_job) begin
                    w_next_state = ST_CLEAR;
                end else if (w_start_empty) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_CLEAR: begin
                o_mr_clr = 1'b1;
                o_busy   = 1'b1;
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_clr_done) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                o_strm_data_rdy = i_mr_data_rdy;
                o_mr_data_valid = i_strm_data_valid;
                o_busy          = 1'b1;
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_last_beat) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_drain_done) begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_job_len    <= '0;
            r_beat_count <= '0;
            r_clr_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_result     <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (w_idle_like && i_job_len_wr) begin
                r_job_len <= i_job_len;
            end

            if (w_start_job || w_start_empty) begin
                r_beat_count <= '0;
            end else if (w_beat) begin
                r_beat_count <= w_beat_inc;
            end

            if ((r_state == ST_CLEAR) && (w_next_state == ST_CLEAR)) begin
                r_clr_cnt <= r_clr_cnt + CLR_W'(1);
            end else begin
                r_clr_cnt <= '0;
            end

            if ((r_state == ST_DRAIN) && (w_next_state == ST_DRAIN)) begin
                r_drain_cnt <= r_drain_cnt + DRN_W'(1);
            end else begin
                r_drain_cnt <= '0;
            end

            if (w_drain_done && !i_abort) begin
                r_result <= i_mr_data_count;
            end else if (w_start_empty) begin
                r_result <= '0;
            end

            // Entering DONE beats a same-cycle acknowledge.
            if (w_enter_done) begin
                r_irq <= 1'b1;
            end else if (i_irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign o_irq        = r_irq;
    assign o_beat_count = r_beat_count;
    assign o_result     = r_result;

endmodule
